// File: rtl/fb_write_arbiter.sv
// Single-port framebuffer arbiter: the display read path owns the port during active video,
// queued host writes retire during blanking. Define FB_CLEAR_EN to add the full-screen fill engine.
module fb_write_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 6,
    parameter int MEM_WORDS  = 3072,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        fifo_count,
`ifdef FB_CLEAR_EN
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
`endif
    output logic              err_range
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);
    localparam logic [2:0] FULL_COUNT = 3'(FIFO_DEPTH);

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRAIN} state_t;
`endif

    state_t state, state_next;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [2:0]        count;
    logic              err_q;

    logic push_take, push_ok, push_bad, pop, in_range;
    logic [2:0] count_next;

`ifdef FB_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_color;
    logic              clr_go;
    logic              clr_step;
`endif

    // Handshake: a beat transfers on a clk edge where wr_valid & wr_ready; wr_ready
    // depends only on the registered count, so the host may hold wr_valid while waiting.
    assign wr_ready   = (count != FULL_COUNT);
    assign in_range   = ({1'b0, wr_addr} < ADDR_LIMIT);
    assign push_take  = wr_valid && wr_ready;
    assign push_ok    = push_take && in_range;
    assign push_bad   = push_take && !in_range;
    assign fifo_count = count;
    assign err_range  = err_q;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 3'd1;
            2'b01:   count_next = count - 3'd1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        mem_addr   = disp_addr;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        pop        = 1'b0;
`ifdef FB_CLEAR_EN
        clr_go     = 1'b0;
        clr_step   = 1'b0;
`endif
        case (state)
`ifdef FB_CLEAR_EN
            CLEAR: begin
                if (!active) begin
                    mem_addr  = clr_cnt;
                    mem_wdata = clr_color;
                    mem_we    = 1'b1;
                    clr_step  = 1'b1;
                    if (clr_cnt == LAST_ADDR) state_next = IDLE;
                end
            end
`endif
            default: begin
                // The head is served straight from registered storage, so a write
                // pushed in one cycle can retire in the very next blanking cycle.
                if (count != 3'd0 && !active) begin
                    mem_addr  = fifo_addr[rd_ptr];
                    mem_wdata = fifo_data[rd_ptr];
                    mem_we    = 1'b1;
                    pop       = 1'b1;
                end
                if (state == IDLE) begin
                    if (count != 3'd0) state_next = DRAIN;
                end else if (count_next == 3'd0) begin
                    state_next = IDLE;
                end
`ifdef FB_CLEAR_EN
                if (clear_start) begin
                    clr_go     = 1'b1;
                    state_next = CLEAR;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_bad) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

`ifdef FB_CLEAR_EN
    assign clear_busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt   <= '0;
            clr_color <= '0;
        end else if (clr_go) begin
            clr_cnt   <= '0;
            clr_color <= clear_color;
        end else if (clr_step) begin
            clr_cnt   <= clr_cnt + 1'b1;
        end
    end
`endif

endmodule
